// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the pixel filter control path.
package pixel_filter_pkg;

  localparam int unsigned PITCH_W   = 30;
  localparam int unsigned PITCH_MIN = 10;
  localparam int unsigned PITCH_MAX = 63;
  localparam int unsigned ACC_W     = 8;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic [SEL_W-1:0] {
    FILT_GRAY     = 3'd0,
    FILT_PINK     = 3'd1,
    FILT_GRAY_ALT = 3'd2,
    FILT_PASS     = 3'd3
  } filter_mode_e;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_e;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus debounce FSM; emits one registered pulse per
// accepted press of an active-low key.
module key_debouncer
  import pixel_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             key_lvl;
  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_set_c;

  assign key_lvl = sync[1];

  // Synchronizer idles high (key released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], key_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_set_c;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (!key_lvl) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_lvl)              state_nxt = RELEASED;
        else if (cnt == CNT_LAST) state_nxt = PRESSED;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      PRESSED: begin
        if (key_lvl) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (!key_lvl)             state_nxt = PRESSED;
        else if (cnt == CNT_LAST) state_nxt = RELEASED;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // Only the PRESS_CHK -> PRESSED transition produces a pulse.
  always_comb begin
    press_set_c = 1'b0;
    if (state == PRESS_CHK && state_nxt == PRESSED) press_set_c = 1'b1;
  end

endmodule

// File: rtl/filter_mode_controller.sv
// Debounced wrap-around mode select and clamped pitch, committed at frame start.
// Define FILTER_PITCH_SMOOTH_EN to enable exponential pitch smoothing.
module filter_mode_controller
  import pixel_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_FILTERS     = 4,
  parameter int unsigned SMOOTH_SHIFT    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n_next,
  input  logic               key_n_prev,
  input  logic               pitch_valid,
  input  logic [PITCH_W-1:0] pitch_data,
  input  logic               frame_start,
  output logic [SEL_W-1:0]   filter_selection,
  output logic [PITCH_W-1:0] pitch_output,
  output logic               mode_changed
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FILTERS - 1);

  if (NUM_FILTERS < 2 || NUM_FILTERS > 8) begin : g_bad_num_filters
    $error("NUM_FILTERS must be in 2..8");
  end
  if (SMOOTH_SHIFT > 7) begin : g_bad_smooth_shift
    $error("SMOOTH_SHIFT must be below 8");
  end

  logic             press_next, press_prev;
  logic [SEL_W-1:0] pending;
  logic [ACC_W-1:0] acc, clamped_c, acc_nxt_c;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk(clk), .reset(reset), .key_n(key_n_next), .press(press_next)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .clk(clk), .reset(reset), .key_n(key_n_prev), .press(press_prev)
  );

  // Simultaneous next/prev presses cancel each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= SEL_W'(FILT_GRAY);
    end else if (press_next && !press_prev) begin
      pending <= (pending == SEL_LAST) ? '0 : pending + SEL_W'(1);
    end else if (press_prev && !press_next) begin
      pending <= (pending == '0) ? SEL_LAST : pending - SEL_W'(1);
    end
  end

  always_comb begin
    if (pitch_data < PITCH_W'(PITCH_MIN))      clamped_c = ACC_W'(PITCH_MIN);
    else if (pitch_data > PITCH_W'(PITCH_MAX)) clamped_c = ACC_W'(PITCH_MAX);
    else                                       clamped_c = ACC_W'(pitch_data);
  end

`ifdef FILTER_PITCH_SMOOTH_EN
  logic signed [ACC_W-1:0] diff_c, step_c, sum_c;

  // Both operands lie in [10,63], so the 8-bit signed difference never overflows.
  always_comb begin
    diff_c = $signed(clamped_c) - $signed(acc);
    step_c = diff_c >>> SMOOTH_SHIFT;
    sum_c  = $signed(acc) + step_c;
    if (sum_c < $signed(ACC_W'(PITCH_MIN)))      acc_nxt_c = ACC_W'(PITCH_MIN);
    else if (sum_c > $signed(ACC_W'(PITCH_MAX))) acc_nxt_c = ACC_W'(PITCH_MAX);
    else                                         acc_nxt_c = ACC_W'(sum_c);
  end
`else
  always_comb acc_nxt_c = clamped_c;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            acc <= ACC_W'(PITCH_MIN);
    else if (pitch_valid) acc <= acc_nxt_c;
  end

  // Commit samples pre-update pending/acc, so same-cycle updates land next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_selection <= SEL_W'(FILT_GRAY);
      pitch_output     <= PITCH_W'(PITCH_MIN);
      mode_changed     <= 1'b0;
    end else if (frame_start) begin
      filter_selection <= pending;
      pitch_output     <= PITCH_W'(acc);
      mode_changed     <= (pending != filter_selection);
    end else begin
      mode_changed     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_mode_controller.sv
// Directed bench for filter_mode_controller with DEBOUNCE_CYCLES=4.
module tb_filter_mode_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n_next;
  logic        key_n_prev;
  logic        pitch_valid;
  logic [29:0] pitch_data;
  logic        frame_start;
  logic [2:0]  filter_selection;
  logic [29:0] pitch_output;
  logic        mode_changed;

  int n_vec = 0;
  int n_bad = 0;

  filter_mode_controller #(
    .DEBOUNCE_CYCLES(4),
    .NUM_FILTERS    (4),
    .SMOOTH_SHIFT   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .key_n_next      (key_n_next),
    .key_n_prev      (key_n_prev),
    .pitch_valid     (pitch_valid),
    .pitch_data      (pitch_data),
    .frame_start     (frame_start),
    .filter_selection(filter_selection),
    .pitch_output    (pitch_output),
    .mode_changed    (mode_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the selected key(s) low long enough to debounce, then releases.
  task automatic press(input logic nxt, input logic prv);
    key_n_next = ~nxt;
    key_n_prev = ~prv;
    tick(12);
    key_n_next = 1'b1;
    key_n_prev = 1'b1;
    tick(12);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic sample(input logic [29:0] d);
    pitch_data  = d;
    pitch_valid = 1'b1;
    tick(1);
    pitch_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    key_n_next  = 1'b1;
    key_n_prev  = 1'b1;
    pitch_valid = 1'b0;
    pitch_data  = '0;
    frame_start = 1'b0;
    tick(3);
    check("rst_sel", 32'(filter_selection), 0);
    check("rst_pitch", 32'(pitch_output), 10);
    check("rst_mc", 32'(mode_changed), 0);
    reset = 1'b0;
    tick(2);

    // Bouncy next key: short low, glitch high, then a stable low.
    key_n_next = 1'b0; tick(3);
    key_n_next = 1'b1; tick(1);
    key_n_next = 1'b0; tick(10);
    key_n_next = 1'b1; tick(12);
    frame();
    check("bounce_sel", 32'(filter_selection), 1);
    check("bounce_mc", 32'(mode_changed), 1);
    tick(1);
    check("bounce_mc_clr", 32'(mode_changed), 0);

    // Wrap-around: 1 -> 0 -> 3 via prev, then 3 -> 0 via next.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("no_commit_yet", 32'(filter_selection), 1);
    frame();
    check("wrap_prev_sel", 32'(filter_selection), 3);
    check("wrap_prev_mc", 32'(mode_changed), 1);
    press(1'b1, 1'b0);
    frame();
    check("wrap_next_sel", 32'(filter_selection), 0);

    // Simultaneous keys cancel; repeated commit gives no pulse.
    press(1'b1, 1'b1);
    frame();
    check("both_sel", 32'(filter_selection), 0);
    check("both_mc", 32'(mode_changed), 0);

    // Pitch clamping and commit-only output updates.
    sample(30'd200);
    check("pitch_hold", 32'(pitch_output), 10);
    frame();
`ifdef FILTER_PITCH_SMOOTH_EN
    check("clamp_hi", 32'(pitch_output), 23);
`else
    check("clamp_hi", 32'(pitch_output), 63);
`endif
    sample(30'd3);
    frame();
`ifdef FILTER_PITCH_SMOOTH_EN
    check("clamp_lo", 32'(pitch_output), 19);
`else
    check("clamp_lo", 32'(pitch_output), 10);
`endif

    // Sample and commit in the same cycle: commit sees the old accumulator.
    pitch_data  = 30'd40;
    pitch_valid = 1'b1;
    frame_start = 1'b1;
    tick(1);
    pitch_valid = 1'b0;
    frame_start = 1'b0;
`ifdef FILTER_PITCH_SMOOTH_EN
    check("collide_old", 32'(pitch_output), 19);
    frame();
    check("collide_new", 32'(pitch_output), 24);
`else
    check("collide_old", 32'(pitch_output), 10);
    frame();
    check("collide_new", 32'(pitch_output), 40);
`endif

    // Commit a nonzero mode, then reset asynchronously mid-debounce.
    press(1'b1, 1'b0);
    frame();
    check("pre_rst_sel", 32'(filter_selection), 1);
    key_n_next = 1'b0;
    tick(4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sel", 32'(filter_selection), 0);
    check("async_rst_pitch", 32'(pitch_output), 10);
    check("async_rst_mc", 32'(mode_changed), 0);
    tick(2);
    key_n_next = 1'b1;
    reset = 1'b0;
    tick(12);
    frame();
    check("post_rst_sel", 32'(filter_selection), 0);
    check("post_rst_pitch", 32'(pitch_output), 10);

    // Back-to-back samples from acc=10.
    sample(30'd50);
    sample(30'd50);
    frame();
`ifdef FILTER_PITCH_SMOOTH_EN
    check("smooth_two", 32'(pitch_output), 27);
`else
    check("smooth_two", 32'(pitch_output), 50);
`endif
    check("smooth_sel", 32'(filter_selection), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
